// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD engine.
// Optional iteration counter: GCD_ITER_COUNT_EN.
package gcd_pkg;

  localparam int GCD_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gcd_engine_dp.sv
// GCD datapath: operand registers, compare, subtract, result.
// Optional iteration counter: GCD_ITER_COUNT_EN.
module gcd_engine_dp
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             calc,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             fin,
  output logic [WIDTH-1:0] result
`ifdef GCD_ITER_COUNT_EN
  ,
  output logic [WIDTH-1:0] iter_count
`endif
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             zero;
  logic             eq_nz;
  logic             gt_nz;
  logic             sub;

  assign zero  = (a_q == '0) || (b_q == '0);
  assign eq_nz = !zero && (a_q == b_q);
  assign gt_nz = !zero && !eq_nz && (a_q > b_q);
  assign fin   = zero || eq_nz;
  assign sub   = calc && !fin;

  // Larger minus smaller only, so the difference never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
    end else if (load) begin
      a_q <= a_in;
      b_q <= b_in;
    end else if (calc) begin
      unique case (1'b1)
        zero:    result <= a_q | b_q;
        eq_nz:   result <= a_q;
        gt_nz:   a_q    <= a_q - b_q;
        default: b_q    <= b_q - a_q;
      endcase
    end
  end

`ifdef GCD_ITER_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst || load) begin
      iter_count <= '0;
    end else if (sub) begin
      iter_count <= iter_count + 1'b1;
    end
  end
`else
  logic unused_sub;
  assign unused_sub = sub;
`endif

endmodule

// File: rtl/gcd_engine.sv
// Subtractive GCD engine: IDLE/CALC/DONE control around a datapath.
// Optional iteration counter: GCD_ITER_COUNT_EN.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef GCD_ITER_COUNT_EN
  ,
  output logic [WIDTH-1:0] iter_count
`endif
);

  state_t state_q;
  logic   load;
  logic   calc;
  logic   fin;

  assign load = (state_q == IDLE) && start;
  assign calc = (state_q == CALC);
  assign busy = (state_q == CALC) || (state_q == DONE);

  // done is registered, so it pulses the cycle after DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done    <= 1'b0;
    end else begin
      done <= (state_q == DONE);
      unique case (state_q)
        IDLE:    if (start) state_q <= CALC;
        CALC:    if (fin) state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  gcd_engine_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .calc      (calc),
    .a_in      (a_in),
    .b_in      (b_in),
    .fin       (fin),
    .result    (result)
`ifdef GCD_ITER_COUNT_EN
    ,
    .iter_count(iter_count)
`endif
  );

endmodule

// File: doc/gcd_engine.md
GCD_ENGINE -- requirements
Module: gcd_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand and result width in bits (legal range 2..64).
REQ-002 The block SHALL have port clk, input, 1 bit, single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit, request to begin a computation; sampled only in IDLE.
REQ-005 The block SHALL have ports a_in and b_in, input, WIDTH bits each, unsigned operands; both captured in parallel on the edge that samples start.
REQ-006 The block SHALL have port busy, output, 1 bit, high in CALC and DONE states.
REQ-007 The block SHALL have port done, output, 1 bit, single-cycle pulse marking a valid result.
REQ-008 The block SHALL have port result, output, WIDTH bits, gcd of captured operands; held stable from done until the next start is accepted.
REQ-009 The block SHALL have port iter_count, output, WIDTH bits, subtraction count of the last computation; present only with GCD_ITER_COUNT_EN.

Function
REQ-010 The FSM SHALL have states IDLE, CALC and DONE.
REQ-011 IDLE with start=1 SHALL capture A<=a_in, B<=b_in and go to CALC; start=0 SHALL stay in IDLE.
REQ-012 CALC, per cycle, priority order: if A==0 or B==0, result<=A|B and go to DONE; else if A==B, result<=A and go to DONE; else if A>B, A<=A-B; else B<=B-A. The state SHALL stay CALC on any subtraction.
REQ-013 Subtraction SHALL be WIDTH-bit unsigned; the operand ordering SHALL guarantee no underflow.
REQ-014 DONE SHALL drive done=1 for exactly one cycle, then go to IDLE.
REQ-015 Latency: done SHALL be high in the cycle following edge E0+N+2, where E0 is the edge that samples start and N is the subtraction count.
REQ-016 gcd(0,0) SHALL equal 0, and gcd(0,x) SHALL equal x, each with N=0.
REQ-017 start while busy=1 SHALL be ignored, with no effect on operands or result.
REQ-018 start asserted in the DONE cycle SHALL be ignored; it is accepted only in IDLE.

Reset
REQ-019 rst=1 SHALL force IDLE, busy=0, done=0, result=0, A=0, B=0 and iter_count=0 on the next edge.
REQ-020 rst SHALL take priority over start and over any in-flight computation, discarding it with no done pulse.

Configuration
REQ-021 With GCD_ITER_COUNT_EN defined, the block SHALL expose iter_count: cleared on start acceptance, +1 per CALC subtraction, final value held with result.
REQ-022 Without GCD_ITER_COUNT_EN, the port and counter SHALL be absent; all other behaviour and latency SHALL be unchanged.

Structure
REQ-023 Package gcd_pkg SHALL hold the state enum (IDLE, CALC, DONE) and the WIDTH default constant.
REQ-024 The datapath (A/B registers, comparator, subtractor, result register) SHALL be sub-module gcd_engine_dp; the FSM SHALL stay in gcd_engine.

Verification
REQ-025 WIDTH=16, a=143, b=78 -> result=13; done at E0+8; iter_count=6.
REQ-026 a=0,b=0 -> result=0; a=0,b=25 -> result=25; each with done at E0+2 and iter_count=0.
REQ-027 a=21,b=21 -> result=21 at E0+2; WIDTH=8, a=255, b=1 -> result=1, iter_count=254.
REQ-028 start pulsed with a=10,b=4 in cycle 3 of a 143/78 run -> result=13, no second done, IDLE after.
REQ-029 rst=1 mid-CALC of 143/78 -> next edge busy=0, result=0, no done; subsequent start a=12,b=18 -> result=6.
